// File: rtl/free_list_pkg.sv
// Shared sizing and tag/pointer types for the physical register free list.
package free_list_pkg;

  localparam int unsigned PHY_REGS  = 64;
  localparam int unsigned PHY_WIDTH = 6;
  localparam int unsigned ARCH_REGS = 32;

  typedef logic [PHY_WIDTH-1:0] phy_tag_t;
  typedef logic [PHY_WIDTH:0]   fl_ptr_t;

  // Tail position after reset: one entry per physical register not mapped at reset.
  localparam fl_ptr_t RESET_TAIL = fl_ptr_t'(PHY_REGS - ARCH_REGS);

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical register tags for the rename stage.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           roll head back to the committed head, no grant this cycle
//   alloc_req[1:0]  per-slot tag request
//   alloc_gnt       combinational all-or-nothing grant
//   alloc_phy_0/1   combinational tags for slot 0/1
//   retire_valid    a destination-writing instruction retires
//   retire_phy_old  tag released by that retirement (tag 0 is never released)
//   free_count      registered speculative free count
//   empty           registered, free_count == 0
//   overflow_err    sticky, release attempted into a full list
module free_list
  import free_list_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [1:0]           alloc_req,
  output logic                 alloc_gnt,
  output logic [PHY_WIDTH-1:0] alloc_phy_0,
  output logic [PHY_WIDTH-1:0] alloc_phy_1,
  input  logic                 retire_valid,
  input  logic [PHY_WIDTH-1:0] retire_phy_old,
  output logic [PHY_WIDTH:0]   free_count,
  output logic                 empty,
  output logic                 overflow_err
);

  phy_tag_t list_q [PHY_REGS];
  fl_ptr_t  head_q, commit_head_q, tail_q;
  fl_ptr_t  head_n, commit_head_n, tail_n;
  fl_ptr_t  count_c, n_c;
  phy_tag_t idx0_c, idx1_c;
  logic     full_c, release_c, push_c;

  // Occupancy and grant from the pre-edge pointers only.
  assign count_c   = tail_q - head_q;
  assign n_c       = fl_ptr_t'(alloc_req[0]) + fl_ptr_t'(alloc_req[1]);
  assign alloc_gnt = (count_c >= n_c) && !flush;

  // Slot 1 takes the head entry when slot 0 is not requesting.
  assign idx0_c      = head_q[PHY_WIDTH-1:0];
  assign idx1_c      = idx0_c + PHY_WIDTH'(alloc_req[0]);
  assign alloc_phy_0 = list_q[idx0_c];
  assign alloc_phy_1 = list_q[idx1_c];

  assign full_c    = (count_c == fl_ptr_t'(PHY_REGS));
  assign release_c = retire_valid && (retire_phy_old != '0);
  assign push_c    = release_c && !full_c;

  // Next pointer values; flush restores the committed head including this cycle's retire.
  always_comb begin
    commit_head_n = commit_head_q + fl_ptr_t'(retire_valid);
    tail_n        = tail_q + fl_ptr_t'(push_c);
    head_n        = head_q;
    if (flush) begin
      head_n = commit_head_n;
    end else if (alloc_gnt) begin
      head_n = head_q + n_c;
    end
  end

  // Storage, pointers and registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(PHY_REGS); i++) begin
        if (i < int'(PHY_REGS - ARCH_REGS)) begin
          list_q[i] <= PHY_WIDTH'(int'(ARCH_REGS) + i);
        end else begin
          list_q[i] <= '0;
        end
      end
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= RESET_TAIL;
      free_count    <= RESET_TAIL;
      empty         <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      if (push_c) begin
        list_q[tail_q[PHY_WIDTH-1:0]] <= retire_phy_old;
      end
      head_q        <= head_n;
      commit_head_q <= commit_head_n;
      tail_q        <= tail_n;
      free_count    <= tail_n - head_n;
      empty         <= (tail_n == head_n);
      overflow_err  <= overflow_err | (release_c & full_c);
    end
  end

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] alloc_req;
  logic       alloc_gnt;
  logic [5:0] alloc_phy_0, alloc_phy_1;
  logic       retire_valid;
  logic [5:0] retire_phy_old;
  logic [6:0] free_count;
  logic       empty;
  logic       overflow_err;

  int total = 0;
  int bad   = 0;

  free_list dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_phy_0(alloc_phy_0), .alloc_phy_1(alloc_phy_1),
    .retire_valid(retire_valid), .retire_phy_old(retire_phy_old),
    .free_count(free_count), .empty(empty), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic       rv;
    logic [5:0] old;
    logic       fl;
    logic       gnt;
    logic [5:0] p0;
    logic [5:0] p1;
    logic [6:0] fc;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge.
  task automatic drive(input logic [1:0] req, input logic rv, input logic [5:0] old,
                       input logic fl);
    alloc_req = req; retire_valid = rv; retire_phy_old = old; flush = fl;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 1'b0, 6'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int fq[$];
    int last;
    int exp_fc;
    bit outstanding [64];

    // req rv old fl | gnt p0 p1 fc_after
    vecs[0] = '{2'b11, 1'b0, 6'd0, 1'b0, 1'b1, 6'd32, 6'd33, 7'd30};
    vecs[1] = '{2'b10, 1'b0, 6'd0, 1'b0, 1'b1, 6'd34, 6'd34, 7'd29};
    vecs[2] = '{2'b01, 1'b0, 6'd0, 1'b0, 1'b1, 6'd35, 6'd36, 7'd28};
    vecs[3] = '{2'b00, 1'b1, 6'd0, 1'b0, 1'b1, 6'd36, 6'd36, 7'd28};
    vecs[4] = '{2'b00, 1'b1, 6'd9, 1'b0, 1'b1, 6'd36, 6'd36, 7'd29};
    vecs[5] = '{2'b11, 1'b0, 6'd0, 1'b1, 1'b0, 6'd36, 6'd37, 7'd31};
    vecs[6] = '{2'b11, 1'b0, 6'd0, 1'b0, 1'b1, 6'd34, 6'd35, 7'd29};

    rst = 1'b1;
    drive(2'b00, 1'b0, 6'd0, 1'b0);
    #12;
    chk("reset_free_count", int'(free_count), 32);
    chk("reset_empty", int'(empty), 0);
    chk("reset_overflow", int'(overflow_err), 0);
    chk("reset_p0", int'(alloc_phy_0), 32);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven sequence from reset.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].req, vecs[i].rv, vecs[i].old, vecs[i].fl);
      settle();
      chk($sformatf("vec%0d_gnt", i), int'(alloc_gnt), int'(vecs[i].gnt));
      chk($sformatf("vec%0d_p0", i), int'(alloc_phy_0), int'(vecs[i].p0));
      chk($sformatf("vec%0d_p1", i), int'(alloc_phy_1), int'(vecs[i].p1));
      tick();
      chk($sformatf("vec%0d_fc", i), int'(free_count), int'(vecs[i].fc));
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].fc == 0));
    end

    // Drain with 16 double allocations, then a refused 17th.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(2'b11, 1'b0, 6'd0, 1'b0);
      settle();
      chk("drain_gnt", int'(alloc_gnt), 1);
      chk("drain_p0", int'(alloc_phy_0), 32 + 2 * k);
      chk("drain_p1", int'(alloc_phy_1), 33 + 2 * k);
      tick();
      chk("drain_fc", int'(free_count), 30 - 2 * k);
    end
    chk("drained_empty", int'(empty), 1);
    drive(2'b11, 1'b0, 6'd0, 1'b0);
    settle();
    chk("empty_gnt", int'(alloc_gnt), 0);
    tick();
    chk("empty_fc_hold", int'(free_count), 0);
    chk("empty_flag_hold", int'(empty), 1);

    // Same-cycle release is not visible to the grant.
    drive(2'b01, 1'b1, 6'd5, 1'b0);
    settle();
    chk("bypass_gnt", int'(alloc_gnt), 0);
    tick();
    chk("bypass_fc", int'(free_count), 1);
    drive(2'b01, 1'b0, 6'd0, 1'b0);
    settle();
    chk("released_gnt", int'(alloc_gnt), 1);
    chk("released_tag", int'(alloc_phy_0), 5);
    tick();
    chk("released_fc", int'(free_count), 0);

    // Flush with same-cycle retire.
    do_reset();
    drive(2'b11, 1'b0, 6'd0, 1'b0); tick();
    drive(2'b01, 1'b0, 6'd0, 1'b0); tick();
    chk("pre_flush_fc", int'(free_count), 29);
    drive(2'b01, 1'b1, 6'd7, 1'b1);
    settle();
    chk("flush_gnt", int'(alloc_gnt), 0);
    tick();
    chk("flush_fc", int'(free_count), 32);
    drive(2'b00, 1'b0, 6'd0, 1'b0);
    settle();
    chk("flush_p0", int'(alloc_phy_0), 33);

    // Slot-1-only request and tag-0 release.
    do_reset();
    drive(2'b10, 1'b0, 6'd0, 1'b0);
    settle();
    chk("slot1_gnt", int'(alloc_gnt), 1);
    chk("slot1_p1", int'(alloc_phy_1), 32);
    tick();
    chk("slot1_fc", int'(free_count), 31);
    drive(2'b00, 1'b1, 6'd0, 1'b0); tick();
    chk("x0_release_fc", int'(free_count), 31);
    drive(2'b01, 1'b0, 6'd0, 1'b0);
    settle();
    chk("slot1_head_p0", int'(alloc_phy_0), 33);

    // Asynchronous reset mid-operation.
    drive(2'b11, 1'b1, 6'd12, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_fc", int'(free_count), 32);
    chk("async_rst_p0", int'(alloc_phy_0), 32);
    chk("async_rst_p1", int'(alloc_phy_1), 33);
    drive(2'b00, 1'b0, 6'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Wrap-around: allocate one and release the previous tag each cycle.
    fq.delete();
    for (int t = 32; t < 64; t++) fq.push_back(t);
    foreach (outstanding[t]) outstanding[t] = 1'b0;
    drive(2'b01, 1'b0, 6'd0, 1'b0);
    settle();
    chk("wrap0_p0", int'(alloc_phy_0), fq[0]);
    last = fq.pop_front();
    outstanding[last] = 1'b1;
    tick();
    for (int k = 0; k < 70; k++) begin
      drive(2'b01, 1'b1, 6'(last), 1'b0);
      settle();
      chk("wrap_p0", int'(alloc_phy_0), fq[0]);
      chk("wrap_unique", int'(outstanding[alloc_phy_0]), 0);
      outstanding[last] = 1'b0;
      fq.push_back(last);
      last = fq.pop_front();
      outstanding[last] = 1'b1;
      tick();
      chk("wrap_fc", int'(free_count), 31);
    end

    // Fill to full, then one release too many.
    exp_fc = 31;
    for (int k = 1; k <= 33; k++) begin
      drive(2'b00, 1'b1, 6'(k), 1'b0);
      tick();
      exp_fc++;
    end
    chk("full_fc", int'(free_count), exp_fc);
    chk("full_no_err", int'(overflow_err), 0);
    drive(2'b00, 1'b1, 6'd40, 1'b0);
    tick();
    chk("overflow_set", int'(overflow_err), 1);
    chk("overflow_fc", int'(free_count), 64);
    drive(2'b00, 1'b0, 6'd0, 1'b0);
    tick(); tick();
    chk("overflow_sticky", int'(overflow_err), 1);
    do_reset();
    chk("overflow_cleared", int'(overflow_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
